// File: rtl/mem_arbiter_if.sv
// Requester and memory_controller handshake bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  // Instruction-fetch requester
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_ready;
  logic [31:0]       inst_data;

  // Load/store requester
  logic              data_valid;
  logic              data_wr;
  logic [2:0]        data_len;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_ready;
  logic [31:0]       data_rdata;

  // memory_controller port
  logic              mc_valid;
  logic              mc_wr;
  logic [2:0]        mc_len;
  logic [ADDR_W-1:0] mc_addr;
  logic [31:0]       mc_wdata;
  logic              mc_abort;
  logic              mc_ready;
  logic [31:0]       mc_rdata;

  modport slave (
    input  inst_valid, inst_addr,
    input  data_valid, data_wr, data_len, data_addr, data_wdata,
    input  mc_ready, mc_rdata,
    output inst_ready, inst_data,
    output data_ready, data_rdata,
    output mc_valid, mc_wr, mc_len, mc_addr, mc_wdata, mc_abort
  );

  modport master (
    output inst_valid, inst_addr,
    output data_valid, data_wr, data_len, data_addr, data_wdata,
    output mc_ready, mc_rdata,
    input  inst_ready, inst_data,
    input  data_ready, data_rdata,
    input  mc_valid, mc_wr, mc_len, mc_addr, mc_wdata, mc_abort
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory_controller port between fetch and load/store, with
// load/store priority, a fetch starvation guard and flush handling that never drops a store.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          clear,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
  localparam logic [2:0] FetchLen = 3'b010;

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              mc_valid_q, mc_valid_d;
  logic              mc_wr_q, mc_wr_d;
  logic [2:0]        mc_len_q, mc_len_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [31:0]       mc_wdata_q, mc_wdata_d;
  logic              mc_abort_q, mc_abort_d;
  logic              inst_ready, data_ready;
  logic              fetch_starved;

  assign fetch_starved = bus.inst_valid && (starve_q == CntMax);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mc_valid_d = mc_valid_q;
    mc_wr_d    = mc_wr_q;
    mc_len_d   = mc_len_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    mc_abort_d = mc_abort_q;
    inst_ready = 1'b0;
    data_ready = 1'b0;

    // With rdy low everything, including the abort pulse, is frozen.
    if (rdy) begin
      mc_abort_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!clear) begin
            if (bus.data_valid && !fetch_starved) begin
              state_d    = StBusyD;
              mc_valid_d = 1'b1;
              mc_wr_d    = bus.data_wr;
              mc_len_d   = bus.data_len;
              mc_addr_d  = bus.data_addr;
              mc_wdata_d = bus.data_wdata;
              if (bus.inst_valid && (starve_q != CntMax)) begin
                starve_d = starve_q + 1'b1;
              end
            end else if (bus.inst_valid) begin
              state_d    = StBusyI;
              starve_d   = '0;
              mc_valid_d = 1'b1;
              mc_wr_d    = 1'b0;
              mc_len_d   = FetchLen;
              mc_addr_d  = bus.inst_addr;
              mc_wdata_d = '0;
            end
          end
        end

        StBusyI, StBusyD: begin
          if (clear) begin
            if ((state_q == StBusyD) && mc_wr_q) begin
              // A store completing in the flush cycle is done; otherwise wait it out in DRAIN.
              if (bus.mc_ready) begin
                state_d    = StIdle;
                mc_valid_d = 1'b0;
              end else begin
                state_d = StDrain;
              end
            end else begin
              state_d    = StIdle;
              mc_valid_d = 1'b0;
              mc_abort_d = 1'b1;
            end
          end else if (bus.mc_ready) begin
            inst_ready = (state_q == StBusyI);
            data_ready = (state_q == StBusyD);
            state_d    = StIdle;
            mc_valid_d = 1'b0;
          end
        end

        StDrain: begin
          if (bus.mc_ready) begin
            state_d    = StIdle;
            mc_valid_d = 1'b0;
          end
        end

        default: begin
          state_d    = StIdle;
          mc_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      mc_valid_q <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_len_q   <= '0;
      mc_addr_q  <= '0;
      mc_wdata_q <= '0;
      mc_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mc_valid_q <= mc_valid_d;
      mc_wr_q    <= mc_wr_d;
      mc_len_q   <= mc_len_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      mc_abort_q <= mc_abort_d;
    end
  end

  assign bus.mc_valid   = mc_valid_q;
  assign bus.mc_wr      = mc_wr_q;
  assign bus.mc_len     = mc_len_q;
  assign bus.mc_addr    = mc_addr_q;
  assign bus.mc_wdata   = mc_wdata_q;
  assign bus.mc_abort   = mc_abort_q;
  assign bus.inst_ready = inst_ready;
  assign bus.data_ready = data_ready;
  assign bus.inst_data  = bus.mc_rdata;
  assign bus.data_rdata = bus.mc_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, starvation, flush and reset/rdy scenarios.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic clear;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .ADDR_W      (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_valid = 1'b0;
    bus.inst_addr  = '0;
    bus.data_valid = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_len   = '0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;
    bus.mc_ready   = 1'b0;
    bus.mc_rdata   = '0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({bus.mc_valid, bus.mc_wr, bus.mc_abort, bus.inst_ready, bus.data_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.mc_valid, bus.mc_wr, bus.mc_abort, bus.inst_ready, bus.data_ready});
    end
    n_tests++;
    if ({bus.mc_len, bus.mc_addr, bus.mc_wdata} !== 67'h0) begin
      n_fail++;
      $display("FAIL reset_bus: len=%h addr=%h wdata=%h want 0", bus.mc_len, bus.mc_addr,
               bus.mc_wdata);
    end
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: mc_valid got %b want 0", bus.mc_valid);
    end
  endtask

  task automatic test_fetch();
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 32'h100;
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_wr !== 1'b0 || bus.mc_len !== 3'b010 ||
        bus.mc_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL fetch_grant: valid=%b wr=%b len=%b addr=%h want 1 0 010 100",
               bus.mc_valid, bus.mc_wr, bus.mc_len, bus.mc_addr);
    end
    repeat (4) step();
    n_tests++;
    if (bus.inst_ready !== 1'b0 || bus.mc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_wait: inst_ready=%b mc_valid=%b want 0 1", bus.inst_ready,
               bus.mc_valid);
    end
    bus.mc_ready = 1'b1;
    bus.mc_rdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (bus.inst_ready !== 1'b1 || bus.inst_data !== 32'hDEADBEEF || bus.data_ready !== 1'b0)
    begin
      n_fail++;
      $display("FAIL fetch_done: inst_ready=%b data=%h data_ready=%b want 1 deadbeef 0",
               bus.inst_ready, bus.inst_data, bus.data_ready);
    end
    step();
    bus.mc_ready   = 1'b0;
    bus.inst_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.mc_valid !== 1'b0 || bus.inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_release: mc_valid=%b inst_ready=%b want 0 0", bus.mc_valid,
               bus.inst_ready);
    end
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_no_regrant: mc_valid got %b want 0", bus.mc_valid);
    end
  endtask

  task automatic test_priority();
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 32'h200;
    bus.data_valid = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_len   = 3'b010;
    bus.data_addr  = 32'h2000;
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h2000 || bus.mc_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_data_first: valid=%b addr=%h wr=%b want 1 2000 0", bus.mc_valid,
               bus.mc_addr, bus.mc_wr);
    end
    bus.mc_ready = 1'b1;
    bus.mc_rdata = 32'h0000_1234;
    #1;
    n_tests++;
    if (bus.data_ready !== 1'b1 || bus.inst_ready !== 1'b0 || bus.data_rdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL prio_data_done: data_ready=%b inst_ready=%b rdata=%h want 1 0 1234",
               bus.data_ready, bus.inst_ready, bus.data_rdata);
    end
    step();
    bus.mc_ready   = 1'b0;
    bus.data_valid = 1'b0;
    n_tests++;
    if (bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_gap: mc_valid got %b want 0", bus.mc_valid);
    end
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h200 || bus.mc_len !== 3'b010) begin
      n_fail++;
      $display("FAIL prio_fetch_next: valid=%b addr=%h len=%b want 1 200 010", bus.mc_valid,
               bus.mc_addr, bus.mc_len);
    end
    bus.mc_ready = 1'b1;
    step();
    bus.mc_ready   = 1'b0;
    bus.inst_valid = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 32'h300;
    bus.data_valid = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_len   = 3'b000;
    bus.data_addr  = 32'h4000;
    for (int g = 0; g < 10; g++) begin
      exp_addr = ((g % 5) == 4) ? 32'h300 : 32'h4000;
      step();
      n_tests++;
      if (bus.mc_valid !== 1'b1 || bus.mc_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL starve_grant%0d: valid=%b addr=%h want 1 %h", g, bus.mc_valid,
                 bus.mc_addr, exp_addr);
      end
      bus.mc_ready = 1'b1;
      step();
      bus.mc_ready = 1'b0;
    end
    bus.inst_valid = 1'b0;
    bus.data_valid = 1'b0;
    step();
  endtask

  task automatic test_clear_load();
    bus.data_valid = 1'b1;
    bus.data_wr    = 1'b0;
    bus.data_len   = 3'b010;
    bus.data_addr  = 32'h5000;
    step();
    step();
    clear        = 1'b1;
    bus.mc_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clrld_no_ready: data_ready got %b want 0", bus.data_ready);
    end
    step();
    n_tests++;
    if (bus.mc_abort !== 1'b1 || bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clrld_abort: abort=%b valid=%b want 1 0", bus.mc_abort, bus.mc_valid);
    end
    clear          = 1'b0;
    bus.mc_ready   = 1'b0;
    bus.data_valid = 1'b0;
    step();
    n_tests++;
    if (bus.mc_abort !== 1'b0 || bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clrld_idle: abort=%b valid=%b want 0 0", bus.mc_abort, bus.mc_valid);
    end
  endtask

  task automatic test_clear_store();
    bus.data_valid = 1'b1;
    bus.data_wr    = 1'b1;
    bus.data_len   = 3'b010;
    bus.data_addr  = 32'h30000;
    bus.data_wdata = 32'hCAFEF00D;
    step();
    n_tests++;
    if (bus.mc_wr !== 1'b1 || bus.mc_addr !== 32'h30000 || bus.mc_wdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL clrst_grant: wr=%b addr=%h wdata=%h want 1 30000 cafef00d", bus.mc_wr,
               bus.mc_addr, bus.mc_wdata);
    end
    clear = 1'b1;
    step();
    clear          = 1'b0;
    bus.data_valid = 1'b0;
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 32'h600;
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL clrst_drain: valid=%b abort=%b want 1 0", bus.mc_valid, bus.mc_abort);
    end
    step();
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h30000 || bus.mc_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL clrst_hold: valid=%b addr=%h wr=%b want 1 30000 1", bus.mc_valid,
               bus.mc_addr, bus.mc_wr);
    end
    bus.mc_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.data_ready !== 1'b0 || bus.inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clrst_no_ready: data_ready=%b inst_ready=%b want 0 0", bus.data_ready,
               bus.inst_ready);
    end
    step();
    bus.mc_ready = 1'b0;
    n_tests++;
    if (bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clrst_idle: mc_valid got %b want 0", bus.mc_valid);
    end
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h600 || bus.mc_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL clrst_fetch_after: valid=%b addr=%h wr=%b want 1 600 0", bus.mc_valid,
               bus.mc_addr, bus.mc_wr);
    end
    bus.mc_ready = 1'b1;
    step();
    bus.mc_ready   = 1'b0;
    bus.inst_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_and_rdy();
    bus.inst_valid = 1'b1;
    bus.inst_addr  = 32'h700;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mc_valid, bus.mc_wr, bus.mc_abort, bus.inst_ready, bus.data_ready} !== 5'b0 ||
        bus.mc_len !== 3'b000 || bus.mc_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b len=%b addr=%h want 0 000 0", bus.mc_valid,
               bus.mc_len, bus.mc_addr);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h700) begin
      n_fail++;
      $display("FAIL reset_regrant: valid=%b addr=%h want 1 700", bus.mc_valid, bus.mc_addr);
    end
    rdy          = 1'b0;
    bus.mc_ready = 1'b1;
    bus.mc_rdata = 32'h0BAD_F00D;
    #1;
    n_tests++;
    if (bus.inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_low_ready: inst_ready got %b want 0", bus.inst_ready);
    end
    repeat (3) step();
    n_tests++;
    if (bus.mc_valid !== 1'b1 || bus.mc_addr !== 32'h700 || bus.inst_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_low_hold: valid=%b addr=%h inst_ready=%b want 1 700 0", bus.mc_valid,
               bus.mc_addr, bus.inst_ready);
    end
    rdy = 1'b1;
    #1;
    n_tests++;
    if (bus.inst_ready !== 1'b1 || bus.inst_data !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL rdy_resume: inst_ready=%b data=%h want 1 0badf00d", bus.inst_ready,
               bus.inst_data);
    end
    step();
    bus.mc_ready   = 1'b0;
    bus.inst_valid = 1'b0;
    n_tests++;
    if (bus.mc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_done_idle: mc_valid got %b want 0", bus.mc_valid);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rdy   = 1'b1;
    clear = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    step();
    test_fetch();
    test_priority();
    test_starvation();
    test_clear_load();
    test_clear_store();
    test_reset_and_rdy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
